// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder output-buffer read scheduler:
// FSM encoding, default block geometry and the per-bank flag vector type.
package turbo_pkg;

    localparam int LEN_SHORT_D = 4;
    localparam int LEN_LONG_D  = 6;
    localparam int TAIL_LEN_D  = 4;
    localparam int CNT_W_D     = 14;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC  = 2'd1;
    localparam logic [1:0] ST_TRL  = 2'd2;

    typedef logic [1:0] bank_vec_t;

endpackage

// File: rtl/turbo_output_scheduler_if.sv
// Write-report, read-request and output-qualifier signals of the scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface turbo_output_scheduler_if;
    import turbo_pkg::*;

    logic      wr_done;
    logic      wr_bank;
    logic      wr_len;
    logic      rd_ready;
    bank_vec_t rd_enc_en;
    bank_vec_t rd_trl_en;
    logic      out_valid;
    logic      out_sel_bank;
    logic      out_sel_trl;
    logic      blk_start;
    logic      blk_end;
    bank_vec_t bank_full;
    logic      overflow_err;
    logic [1:0] state;

    modport slave (
        input  wr_done, wr_bank, wr_len, rd_ready,
        output rd_enc_en, rd_trl_en, out_valid, out_sel_bank, out_sel_trl,
               blk_start, blk_end, bank_full, overflow_err, state
    );

    modport master (
        output wr_done, wr_bank, wr_len, rd_ready,
        input  rd_enc_en, rd_trl_en, out_valid, out_sel_bank, out_sel_trl,
               blk_start, blk_end, bank_full, overflow_err, state
    );

endinterface

// File: rtl/turbo_bank_tracker.sv
// Per-bank occupancy and length flags for the ping-pong buffers, plus the
// sticky overflow flag. A release in the same cycle frees the bank for a write.
module turbo_bank_tracker
    import turbo_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wr_done,
    input  logic      i_wr_bank,
    input  logic      i_wr_len,
    input  logic      i_rel,
    input  logic      i_rel_bank,
    output bank_vec_t o_bank_full,
    output bank_vec_t o_len_flag,
    output logic      o_overflow_err
);

    bank_vec_t r_full;
    bank_vec_t r_len;
    logic      r_ovf;
    bank_vec_t w_wr_hit;
    bank_vec_t w_rel_hit;

    assign w_wr_hit  = {2{i_wr_done}} & (2'b01 << i_wr_bank);
    assign w_rel_hit = {2{i_rel}}     & (2'b01 << i_rel_bank);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_hit[b]) begin
                    // An occupied bank keeps its block and length; the write is dropped.
                    if (r_full[b] && !w_rel_hit[b]) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_full[b] <= 1'b1;
                        r_len[b]  <= i_wr_len;
                    end
                end else if (w_rel_hit[b]) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    assign o_bank_full    = r_full;
    assign o_len_flag     = r_len;
    assign o_overflow_err = r_ovf;

endmodule

// File: rtl/turbo_output_scheduler.sv
// Drains the turbo encoder ping-pong banks in strict alternation: K encoded
// triples then TAIL_LEN tail triples per block, with registered mux qualifiers.
module turbo_output_scheduler
    import turbo_pkg::*;
#(
    parameter int LEN_SHORT = LEN_SHORT_D,
    parameter int LEN_LONG  = LEN_LONG_D,
    parameter int TAIL_LEN  = TAIL_LEN_D,
    parameter int CNT_W     = CNT_W_D
) (
    input logic clk,
    input logic rst,
    turbo_output_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] C_SHORT_LAST = CNT_W'(LEN_SHORT - 1);
    localparam logic [CNT_W-1:0] C_LONG_LAST  = CNT_W'(LEN_LONG - 1);
    localparam logic [CNT_W-1:0] C_TAIL_LAST  = CNT_W'(TAIL_LEN - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_bank;
    logic             r_out_valid;
    logic             r_sel_bank;
    logic             r_sel_trl;
    logic             r_blk_start;
    logic             r_blk_end;

    bank_vec_t        w_bank_full;
    bank_vec_t        w_len_flag;
    logic             w_overflow;
    logic             w_in_enc;
    logic             w_in_trl;
    logic             w_issue;
    logic             w_last_enc;
    logic             w_last_trl;
    logic [CNT_W-1:0] w_k_last;

    turbo_bank_tracker u_bank_tracker (
        .clk            (clk),
        .rst            (rst),
        .i_wr_done      (bus.wr_done),
        .i_wr_bank      (bus.wr_bank),
        .i_wr_len       (bus.wr_len),
        .i_rel          (w_last_trl),
        .i_rel_bank     (r_rd_bank),
        .o_bank_full    (w_bank_full),
        .o_len_flag     (w_len_flag),
        .o_overflow_err (w_overflow)
    );

    assign w_k_last   = w_len_flag[r_rd_bank] ? C_LONG_LAST : C_SHORT_LAST;
    assign w_in_enc   = (r_state == ST_ENC);
    assign w_in_trl   = (r_state == ST_TRL);
    assign w_issue    = bus.rd_ready & (w_in_enc | w_in_trl);
    assign w_last_enc = w_issue & w_in_enc & (r_cnt == w_k_last);
    assign w_last_trl = w_issue & w_in_trl & (r_cnt == C_TAIL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bank_full[r_rd_bank]) begin
                        r_state <= ST_ENC;
                        r_cnt   <= '0;
                    end
                end
                ST_ENC: begin
                    if (w_last_enc) begin
                        r_state <= ST_TRL;
                        r_cnt   <= '0;
                    end else if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_TRL: begin
                    if (w_last_trl) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_rd_bank <= ~r_rd_bank;
                    end else if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // FIFO q appears one cycle after the request, so qualifiers trail the issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sel_bank  <= 1'b0;
            r_sel_trl   <= 1'b0;
            r_blk_start <= 1'b0;
            r_blk_end   <= 1'b0;
        end else begin
            r_out_valid <= w_issue;
            r_blk_start <= w_issue & w_in_enc & (r_cnt == '0);
            r_blk_end   <= w_last_trl;
            if (w_issue) begin
                r_sel_bank <= r_rd_bank;
                r_sel_trl  <= w_in_trl;
            end
        end
    end

    assign bus.rd_enc_en    = {2{w_issue & w_in_enc}} & (2'b01 << r_rd_bank);
    assign bus.rd_trl_en    = {2{w_issue & w_in_trl}} & (2'b01 << r_rd_bank);
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sel_bank = r_sel_bank;
    assign bus.out_sel_trl  = r_sel_trl;
    assign bus.blk_start    = r_blk_start;
    assign bus.blk_end      = r_blk_end;
    assign bus.bank_full    = w_bank_full;
    assign bus.overflow_err = w_overflow;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_turbo_output_scheduler.sv
// Bench for turbo_output_scheduler: directed ping-pong scenarios then random
// traffic, every cycle compared against a block-position reference model.
module tb_turbo_output_scheduler;
    import turbo_pkg::*;

    localparam int K_SHORT = 4;
    localparam int K_LONG  = 6;
    localparam int TAIL    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turbo_output_scheduler_if bus ();

    turbo_output_scheduler #(
        .LEN_SHORT (K_SHORT),
        .LEN_LONG  (K_LONG),
        .TAIL_LEN  (TAIL),
        .CNT_W     (14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    int vld_seen = 0;

    // Reference model: bank contents plus "which triple of the block is next".
    logic [1:0] m_full = '0;
    logic [1:0] m_len  = '0;
    bit m_ovf = 0, m_drain = 0, m_rdb = 0;
    bit m_vld = 0, m_selb = 0, m_selt = 0, m_bs = 0, m_be = 0;
    int m_pos = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int blk_k(input bit f);
        return f ? K_LONG : K_SHORT;
    endfunction

    task automatic model_reset();
        m_full = '0; m_len = '0; m_ovf = 0; m_drain = 0; m_rdb = 0; m_pos = 0;
        m_vld = 0; m_selb = 0; m_selt = 0; m_bs = 0; m_be = 0;
    endtask

    task automatic step(input bit r, input bit wd, input bit wb, input bit wl, input bit rdy);
        int k;
        bit iss, rel, old_rdb, hit, rb;
        logic [1:0] old_full, e_sel, e_enc, e_trl, e_st;
        rst = r;
        bus.wr_done = wd; bus.wr_bank = wb; bus.wr_len = wl; bus.rd_ready = rdy;
        @(negedge clk);
        k     = blk_k(m_len[m_rdb]);
        iss   = m_drain && rdy;
        e_sel = 2'b01 << m_rdb;
        e_enc = (iss && m_pos < k)  ? e_sel : 2'b00;
        e_trl = (iss && m_pos >= k) ? e_sel : 2'b00;
        e_st  = !m_drain ? 2'd0 : (m_pos < k ? 2'd1 : 2'd2);
        check_eq("rd_enc_en",    32'(bus.rd_enc_en),    32'(e_enc));
        check_eq("rd_trl_en",    32'(bus.rd_trl_en),    32'(e_trl));
        check_eq("state",        32'(bus.state),        32'(e_st));
        check_eq("out_valid",    32'(bus.out_valid),    32'(m_vld));
        check_eq("out_sel_bank", 32'(bus.out_sel_bank), 32'(m_selb));
        check_eq("out_sel_trl",  32'(bus.out_sel_trl),  32'(m_selt));
        check_eq("blk_start",    32'(bus.blk_start),    32'(m_bs));
        check_eq("blk_end",      32'(bus.blk_end),      32'(m_be));
        check_eq("bank_full",    32'(bus.bank_full),    32'(m_full));
        check_eq("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
        if (bus.out_valid) vld_seen++;
        if (r) begin
            model_reset();
        end else begin
            rel      = iss && (m_pos == k + TAIL - 1);
            old_rdb  = m_rdb;
            old_full = m_full;
            m_vld = iss;
            if (iss) begin
                m_selb = m_rdb;
                m_selt = (m_pos >= k);
            end
            m_bs = iss && (m_pos == 0);
            m_be = rel;
            if (!m_drain) begin
                if (old_full[old_rdb]) begin
                    m_drain = 1; m_pos = 0;
                end
            end else if (iss) begin
                if (rel) begin
                    m_drain = 0; m_pos = 0; m_rdb = !old_rdb;
                end else begin
                    m_pos++;
                end
            end
            for (int b = 0; b < 2; b++) begin
                hit = wd && (wb == b[0]);
                rb  = rel && (old_rdb == b[0]);
                if (hit) begin
                    if (old_full[b] && !rb) m_ovf = 1;
                    else begin
                        m_full[b] = 1'b1;
                        m_len[b]  = wl;
                    end
                end else if (rb) begin
                    m_full[b] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    logic [15:0] bp_pat;
    bit armed;

    initial begin
        rst = 1'b1;
        bus.wr_done = 0; bus.wr_bank = 0; bus.wr_len = 0; bus.rd_ready = 0;
        @(posedge clk);
        #1;
        model_reset();
        step(1, 0, 0, 0, 1);

        // Single short block on bank 0.
        vld_seen = 0;
        step(0, 1, 0, 0, 1);
        idle(12);
        check_eq("single_vld_cnt", 32'(vld_seen), 32'd8);

        // Ping-pong: long block on bank 0, short block queued on bank 1.
        step(1, 0, 0, 0, 1);
        vld_seen = 0;
        step(0, 1, 0, 1, 1);
        step(0, 1, 1, 0, 1);
        idle(22);
        check_eq("pingpong_vld_cnt", 32'(vld_seen), 32'd18);

        // Backpressure on the 3rd enc and 2nd tail issue slot.
        step(1, 0, 0, 0, 1);
        vld_seen = 0;
        bp_pat = 16'b1111_1110_1110_1111;
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, bp_pat[i]);
        check_eq("backpr_vld_cnt", 32'(vld_seen), 32'd8);

        // Overflow: both banks full, then another write to bank 1.
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 1, 1);
        step(0, 1, 1, 0, 1);
        idle(24);
        check_eq("ovf_sticky", 32'(bus.overflow_err), 32'd1);

        // Same-cycle release and rewrite of bank 0.
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        armed = 1;
        for (int i = 0; i < 40; i++) begin
            if (armed && m_drain && !m_rdb && m_pos == blk_k(m_len[0]) + TAIL - 1) begin
                armed = 0;
                step(0, 1, 0, 1, 1);
            end else begin
                step(0, 0, 0, 0, 1);
            end
        end
        check_eq("release_write_seen", 32'(armed), 32'd0);

        // Reset in the middle of an enc run.
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 10 && !(m_drain && m_pos == 2); i++) step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        vld_seen = 0;
        idle(6);
        check_eq("reset_abort_vld", 32'(vld_seen), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
